// File: rtl/gol_sequencer.sv
// Game-of-Life generation sequencer: drives board transfer select lines,
// paces the algorithm engine at a speed-dependent rate, and tracks generation
// count, extinction and engine-timeout status.
module gol_sequencer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned GEN_W    = 16,
  parameter int unsigned DONE_TMO = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_load,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic [1:0]       speed,
  input  logic [255:0]     board_i,
  input  logic             eng_done,
  output logic             eng_start,
  output logic [2:0]       select,
  output logic [GEN_W-1:0] gen_count,
  output logic [2:0]       state_o,
  output logic             extinct,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RUN_WAIT = 3'd2,
    COMPUTE  = 3'd3,
    CHECK    = 3'd4,
    PAUSED   = 3'd5,
    HALT     = 3'd6
  } state_t;

  localparam int unsigned TW = $clog2(TICK_DIV + 1);
  localparam int unsigned WW = $clog2(DONE_TMO + 1);

  state_t        state;
  logic [TW-1:0] tick;
  logic [WW-1:0] wd;
  logic          step_gen;
  logic [31:0]   period;
  logic [31:0]   period_m1;
  logic          tick_term;
  logic          wd_term;

  // Period follows speed combinationally so a speed change acts on the very
  // next clock; a zero period (tiny TICK_DIV) is treated as one clock.
  always_comb begin
    period    = 32'(TICK_DIV) >> speed;
    period_m1 = (period == 32'd0) ? 32'd0 : period - 32'd1;
    tick_term = 32'(tick) >= period_m1;
    wd_term   = 32'(wd) >= 32'(DONE_TMO - 1);
  end

  // Sequencer FSM with registered status outputs and a one-cycle eng_start
  // pulse raised on every entry into COMPUTE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      eng_start <= 1'b0;
      gen_count <= '0;
      extinct   <= 1'b0;
      err       <= 1'b0;
      tick      <= '0;
      step_gen  <= 1'b0;
      wd        <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_load) begin
            state <= LOAD;
          end else if (btn_run) begin
            tick  <= '0;
            state <= RUN_WAIT;
          end
        end
        LOAD: begin
          gen_count <= '0;
          extinct   <= 1'b0;
          err       <= 1'b0;
          step_gen  <= 1'b0;
          state     <= IDLE;
        end
        RUN_WAIT: begin
          // Pausing leaves tick untouched so resume continues the period.
          if (btn_load) begin
            state <= LOAD;
          end else if (btn_run) begin
            state <= PAUSED;
          end else if (tick_term) begin
            eng_start <= 1'b1;
            tick      <= '0;
            wd        <= '0;
            state     <= COMPUTE;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        COMPUTE: begin
          if (eng_done) begin
            gen_count <= gen_count + GEN_W'(1);
            state     <= CHECK;
          end else if (wd_term) begin
            err      <= 1'b1;
            step_gen <= 1'b0;
            state    <= HALT;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        CHECK: begin
          step_gen <= 1'b0;
          if (board_i == '0) begin
            extinct <= 1'b1;
            state   <= HALT;
          end else if (step_gen) begin
            state <= PAUSED;
          end else begin
            state <= RUN_WAIT;
          end
        end
        PAUSED: begin
          if (btn_load) begin
            state <= LOAD;
          end else if (btn_run) begin
            state <= RUN_WAIT;
          end else if (btn_step) begin
            eng_start <= 1'b1;
            step_gen  <= 1'b1;
            wd        <= '0;
            state     <= COMPUTE;
          end
        end
        HALT: begin
          if (btn_load) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o = state;
  assign select  = {state == HALT, state == COMPUTE, (state == IDLE) || (state == LOAD)};

endmodule

// File: tb/tb_gol_sequencer.sv
// Testbench for gol_sequencer: directed scenarios with literal expectations,
// then randomized buttons/speed/board/engine latency against a cycle model.
module tb_gol_sequencer;

  localparam int TICK_DIV = 8;
  localparam int GEN_W    = 4;
  localparam int DONE_TMO = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             btn_load = 1'b0;
  logic             btn_run = 1'b0;
  logic             btn_step = 1'b0;
  logic [1:0]       speed = 2'd0;
  logic [255:0]     board_i = '1;
  logic             eng_done = 1'b0;
  logic             eng_start;
  logic [2:0]       select;
  logic [GEN_W-1:0] gen_count;
  logic [2:0]       state_o;
  logic             extinct;
  logic             err;

  int total = 0;
  int bad   = 0;

  // engine behaviour knobs: eng_lat < 0 means random latency
  int eng_lat = 2;
  bit spur    = 1'b0;
  int pend    = 0;

  // behavioural model: mode number uses the documented state numbering
  int m_state = 0;
  int m_tick  = 0;   // clocks elapsed in the current period
  int m_busy  = 0;   // clocks spent waiting on the engine
  int m_gen   = 0;
  bit m_step  = 1'b0;
  bit m_ext   = 1'b0;
  bit m_err   = 1'b0;
  bit m_start = 1'b0;

  gol_sequencer #(
    .TICK_DIV(TICK_DIV),
    .GEN_W   (GEN_W),
    .DONE_TMO(DONE_TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_load (btn_load),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .speed    (speed),
    .board_i  (board_i),
    .eng_done (eng_done),
    .eng_start(eng_start),
    .select   (select),
    .gen_count(gen_count),
    .state_o  (state_o),
    .extinct  (extinct),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_tick = 0; m_busy = 0; m_gen = 0;
    m_step = 1'b0; m_ext = 1'b0; m_err = 1'b0; m_start = 1'b0;
  endfunction

  function automatic void model_clock();
    int per;
    per = TICK_DIV >> speed;
    if (per < 1) per = 1;
    m_start = 1'b0;
    case (m_state)
      0: if (btn_load) m_state = 1;
         else if (btn_run) begin m_state = 2; m_tick = 0; end
      1: begin m_gen = 0; m_ext = 1'b0; m_err = 1'b0; m_step = 1'b0; m_state = 0; end
      2: if (btn_load) m_state = 1;
         else if (btn_run) m_state = 5;
         else if (m_tick + 1 >= per) begin
           m_start = 1'b1; m_tick = 0; m_busy = 0; m_state = 3;
         end else m_tick = m_tick + 1;
      3: begin
           m_busy = m_busy + 1;
           if (eng_done) begin
             m_gen = (m_gen + 1) % (1 << GEN_W);
             m_state = 4;
           end else if (m_busy >= DONE_TMO) begin
             m_err = 1'b1; m_step = 1'b0; m_state = 6;
           end
         end
      4: begin
           if (board_i == '0) begin m_ext = 1'b1; m_state = 6; end
           else m_state = m_step ? 5 : 2;
           m_step = 1'b0;
         end
      5: if (btn_load) m_state = 1;
         else if (btn_run) m_state = 2;
         else if (btn_step) begin
           m_start = 1'b1; m_step = 1'b1; m_busy = 0; m_state = 3;
         end
      6: if (btn_load) m_state = 1;
      default: m_state = 0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_clock();
  end

  // compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    check("state", int'(state_o), m_state);
    check("select", int'(select), int'({m_state == 6, m_state == 3, m_state <= 1}));
    check("eng_start", int'(eng_start), int'(m_start));
    check("gen_count", int'(gen_count), m_gen);
    check("extinct", int'(extinct), int'(m_ext));
    check("err", int'(err), int'(m_err));
  end

  // engine stand-in: answers each start after a latency, plus stray pulses
  always @(negedge clk) begin
    int lat;
    eng_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) eng_done = 1'b1;
    end
    if (m_start) begin
      if (eng_lat >= 0) lat = eng_lat;
      else if ($urandom_range(0, 19) == 0) lat = 40;
      else lat = $urandom_range(0, 4);
      pend = lat;
      if (lat == 0) eng_done = 1'b1;
    end
    if (spur && $urandom_range(0, 39) == 0) eng_done = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit l, input bit r, input bit s);
    btn_load = l; btn_run = r; btn_step = s;
    @(negedge clk);
    btn_load = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    int n = 0;
    while (int'(state_o) != s && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(state_o), s);
  endtask

  task automatic rand_board();
    for (int unsigned w = 0; w < 8; w++) board_i[w*32 +: 32] = $urandom;
    if (board_i == '0) board_i[0] = 1'b1;
  endtask

  initial begin
    int n;
    rand_board();
    cyc(3);
    check("rst_state", int'(state_o), 0);
    check("rst_select", int'(select), 1);
    check("rst_gen", int'(gen_count), 0);
    reset = 1'b0;
    cyc(1);

    // load, run, pause with the tick counter at 3
    press(1, 0, 0);
    check("load_state", int'(state_o), 1);
    cyc(1);
    press(0, 1, 0);
    check("run_select", int'(select), 0);
    cyc(3);
    press(0, 1, 0);
    check("pause_state", int'(state_o), 5);

    // single steps; 16 steps with a 4-bit counter wraps back to zero
    eng_lat = 2;
    for (int i = 0; i < 16; i++) begin
      press(0, 0, 1);
      check("step_start", int'(eng_start), 1);
      wait_state(5, 20, "step_return");
      if (i == 2) check("step_gen3", int'(gen_count), 3);
    end
    check("gen_wrap", int'(gen_count), 0);

    // resume continues from held tick 3: terminal at tick 7 -> 5 clocks
    press(0, 1, 0);
    n = 0;
    while (!eng_start && n < 50) begin cyc(1); n++; end
    check("resume_delay", n, 5);
    // full period 8 + 3 engine clocks + 1 check clock
    cyc(1);
    n = 1;
    while (!eng_start && n < 50) begin cyc(1); n++; end
    check("start_interval", n, 12);

    // speed 3: start on first RUN_WAIT clock after CHECK
    speed = 2'd3;
    wait_state(4, 20, "reach_check");
    cyc(1);
    check("fast_runwait", int'(state_o), 2);
    cyc(1);
    check("fast_start", int'(eng_start), 1);

    // extinction
    board_i = '0;
    wait_state(6, 30, "extinct_halt");
    check("extinct_flag", int'(extinct), 1);
    check("halt_select", int'(select), 4);
    press(0, 1, 0);
    check("halt_ignores_run", int'(state_o), 6);
    press(0, 0, 1);
    check("halt_ignores_step", int'(state_o), 6);
    press(1, 0, 0);
    cyc(1);
    check("reload_gen", int'(gen_count), 0);
    check("reload_extinct", int'(extinct), 0);

    // engine timeout
    rand_board();
    eng_lat = 1000;
    press(0, 1, 0);
    wait_state(6, 40, "timeout_halt");
    check("timeout_err", int'(err), 1);
    check("timeout_extinct", int'(extinct), 0);

    // load beats run from PAUSED
    press(1, 0, 0);
    cyc(1);
    speed = 2'd0;
    eng_lat = 2;
    press(0, 1, 0);
    press(0, 1, 0);
    press(1, 1, 0);
    check("load_over_run", int'(state_o), 1);
    cyc(1);

    // reset mid-COMPUTE abandons the generation; late eng_done ignored
    speed = 2'd3;
    eng_lat = 3;
    press(0, 1, 0);
    wait_state(3, 10, "reach_compute");
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    cyc(1);
    check("midrst_state", int'(state_o), 0);
    check("midrst_select", int'(select), 1);
    cyc(6);
    check("late_done_ignored", int'(state_o), 0);

    // randomized phase
    eng_lat = -1;
    spur = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) board_i = '0;
      else rand_board();
      btn_load = (r < 5);
      btn_run  = (r >= 5 && r < 40) || ($urandom_range(0, 99) < 2);
      btn_step = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
      @(negedge clk);
    end
    btn_load = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, time=%0t limit=2000000", $time);
    $fatal(1);
  end

endmodule

// File: doc/gol_sequencer.md
GOL_SEQUENCER -- requirements
Module: gol_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clocks per generation at speed 0.
REQ-002 Parameter GEN_W, default 16: generation counter width.
REQ-003 Parameter DONE_TMO, default 1024: maximum clocks to wait for eng_done.
REQ-004 Port list SHALL be exactly as follows, one line per port.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- btn_load  in  1  one-cycle pulse; request copy of setup board.
- btn_run  in  1  one-cycle pulse; toggle run/pause.
- btn_step  in  1  one-cycle pulse; single generation while paused.
- speed  in  2  period = TICK_DIV >> speed.
- board_i  in  256  registered board currently driven by the transfer stage.
- eng_done  in  1  algorithm engine finished one generation.
- eng_start  out  1  one-cycle pulse; start one generation.
- select  out  3  transfer-stage select.
- gen_count  out  GEN_W  generations completed since last load.
- state_o  out  3  current state encoding.
- extinct  out  1  board reached all-zero.
- err  out  1  engine timeout.

Function
REQ-005 States and encodings SHALL be: IDLE=0, LOAD=1, RUN_WAIT=2, COMPUTE=3, CHECK=4, PAUSED=5, HALT=6; state_o = encoding.
REQ-006 select[0] SHALL be 1 in IDLE and LOAD, otherwise 0; select[1] SHALL be 1 in COMPUTE only; select[2] SHALL be 1 in HALT only.
REQ-007 IDLE: btn_load -> LOAD; btn_run -> RUN_WAIT with tick counter cleared.
REQ-008 LOAD SHALL last exactly one cycle, clear gen_count, extinct and err, then -> IDLE.
REQ-009 RUN_WAIT: tick counter increments each clock; at count = period-1, eng_start SHALL pulse one cycle, counter clears, -> COMPUTE.
REQ-010 RUN_WAIT: btn_run -> PAUSED with tick counter held; on resume, counting SHALL continue from the held value.
REQ-011 speed changes SHALL take effect immediately; if counter >= new period-1, terminal action SHALL occur on the next clock.
REQ-012 COMPUTE: on eng_done -> CHECK and gen_count increments, wrapping from all-ones to 0; a per-run watchdog SHALL force HALT with err=1 if eng_done is absent for DONE_TMO clocks.
REQ-013 CHECK SHALL last one cycle: board_i == 0 -> HALT with extinct=1; otherwise -> PAUSED if the generation was step-initiated, else -> RUN_WAIT.
REQ-014 PAUSED: btn_run -> RUN_WAIT; btn_step -> eng_start pulse same cycle as transition, step flag set, -> COMPUTE.
REQ-015 HALT: only btn_load is accepted (-> LOAD); btn_run and btn_step SHALL be ignored.
REQ-016 btn_load SHALL be accepted in IDLE, RUN_WAIT, PAUSED and HALT; all buttons SHALL be ignored (not queued) in LOAD, COMPUTE and CHECK.
REQ-017 Simultaneous buttons SHALL resolve by priority load > run > step.
REQ-018 eng_start SHALL never assert outside a transition into COMPUTE; eng_done outside COMPUTE SHALL be ignored.

Reset
REQ-019 reset SHALL asynchronously force: state IDLE, select=3'b001, eng_start=0, gen_count=0, extinct=0, err=0, tick counter=0, step flag=0, watchdog=0.
REQ-020 reset asserted mid-COMPUTE SHALL abandon the generation; a later eng_done SHALL have no effect.

Verification (TICK_DIV=8, DONE_TMO=16)
REQ-021 Reset, btn_load, then btn_run, speed=0 -> select 001->000, eng_start pulses every 8 clocks plus engine latency; gen_count increments per eng_done.
REQ-022 Running, speed=3 -> period 1; eng_start issued on the first RUN_WAIT clock after each CHECK.
REQ-023 Paused, btn_step pulses x3 with eng_done 2 clocks after start -> gen_count=3, state returns to 5 after each.
REQ-024 board_i=0 at CHECK -> state 6, extinct=1, select=100; btn_run ignored; btn_load -> gen_count=0, extinct=0.
REQ-025 eng_done withheld 16 clocks -> state 6, err=1, extinct=0.
REQ-026 btn_load and btn_run in the same cycle from PAUSED -> LOAD taken; reset pulse mid-COMPUTE -> IDLE, select=001.
